ps_config_ctrl: RTL and testbench

Parametrised passive-serial FPGA configuration engine for the TSXB CPLD. It sequences nCONFIG, waits for nSTATUS, and buffers host bitstream words in a FIFO. It serialises the words onto DCLK/DATA0 at a programmable rate and issues post-CONF_DONE init clocks. It reports progress and error status back to the ZX-BUS port decoder, which supplies single-cycle write strobes already resynchronised to CLK50.

---
 rtl/ps_config_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ps_config_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_config_ctrl.sv
// Passive-serial FPGA configuration engine: nCONFIG/nSTATUS handshake, bitstream FIFO,
// LSB-first DCLK/DATA0 serialiser and post-CONF_DONE init clocks.
module ps_config_ctrl #(
    parameter int unsigned DW           = 8,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned NCFG_LOW_CYC = 100,
    parameter int unsigned NSTAT_TMO    = 50000,
    parameter int unsigned INIT_CLKS    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic                          wr_stb_i,
    input  logic [DW-1:0]                 wr_data_i,
    input  logic                          nstatus_i,
    input  logic                          conf_done_i,
    output logic                          nconfig_low_o,
    output logic                          pin_oe_o,
    output logic                          dclk_o,
    output logic                          data0_o,
    output logic                          fifo_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [1:0]                    err_code_o
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW   = AW + 1;
    localparam int unsigned BitW   = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned Max1   = (NCFG_LOW_CYC > NSTAT_TMO) ? NCFG_LOW_CYC : NSTAT_TMO;
    localparam int unsigned CntMax = (Max1 > INIT_CLKS) ? Max1 : INIT_CLKS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle, StNcfg, StWaitNs, StShift, StInit, StDone, StError
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        ns_sync_q, cd_sync_q;
    logic              nstatus_s, conf_done_s;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DW-1:0]     sh_q, sh_d;
    logic              sh_valid_q, sh_valid_d;
    logic              dclk_q, dclk_d;
    logic              data0_q, data0_d;
    logic [1:0]        err_q, err_d;
    logic              ncfg_q, oe_q, busy_q, done_q, error_q;

    logic [DW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LvlW-1:0]   level_q;
    logic              fifo_empty, fifo_full, busy_now;
    logic              push, pop, flush, overflow, phase_end;

    assign nstatus_s   = ns_sync_q[1];
    assign conf_done_s = cd_sync_q[1];
    assign fifo_empty  = (level_q == '0);
    assign fifo_full   = (level_q == LvlW'(FIFO_DEPTH));
    assign busy_now    = state_q inside {StNcfg, StWaitNs, StShift, StInit};
    assign phase_end   = (div_q == DivW'(CLK_DIV - 1));
    // A pop frees a slot in the same cycle, so a push on a full FIFO is then legal.
    assign push        = wr_stb_i && busy_now && (!fifo_full || pop) && !flush;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ns_sync_q <= '0;
            cd_sync_q <= '0;
        end else begin
            ns_sync_q <= {ns_sync_q[0], nstatus_i};
            cd_sync_q <= {cd_sync_q[0], conf_done_i};
        end
    end

    always_comb begin
        pop        = (state_q == StShift) && !sh_valid_q && !fifo_empty && nstatus_s &&
                     !conf_done_s;
        overflow   = busy_now && wr_stb_i && fifo_full && !pop;
        flush      = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        sh_valid_d = sh_valid_q;
        dclk_d     = dclk_q;
        data0_d    = data0_q;
        err_d      = err_q;

        case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d = StNcfg;
                    cnt_d   = '0;
                    err_d   = 2'b00;
                    flush   = 1'b1;
                end
            end
            StNcfg: begin
                if (cnt_q == CntW'(NCFG_LOW_CYC - 1)) begin
                    state_d = StWaitNs;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitNs: begin
                if (nstatus_s) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(NSTAT_TMO - 1)) begin
                    state_d = StError;
                    err_d   = 2'b01;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (!nstatus_s) begin
                    state_d = StError;
                    err_d   = 2'b10;
                end else if (conf_done_s && (!dclk_q || phase_end)) begin
                    // Leave only from a low phase or at the end of a high phase.
                    state_d    = StInit;
                    cnt_d      = '0;
                    div_d      = '0;
                    dclk_d     = 1'b0;
                    data0_d    = 1'b0;
                    sh_valid_d = 1'b0;
                    flush      = 1'b1;
                end else if (sh_valid_q) begin
                    if (phase_end) begin
                        div_d = '0;
                        if (!dclk_q) begin
                            dclk_d = 1'b1;
                        end else begin
                            dclk_d = 1'b0;
                            if (bit_q == BitW'(DW - 1)) begin
                                sh_valid_d = 1'b0;
                            end else begin
                                bit_d   = bit_q + 1'b1;
                                sh_d    = sh_q >> 1;
                                data0_d = sh_q[1];
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end else if (pop) begin
                    sh_d       = mem_q[rptr_q];
                    data0_d    = mem_q[rptr_q][0];
                    bit_d      = '0;
                    div_d      = '0;
                    dclk_d     = 1'b0;
                    sh_valid_d = 1'b1;
                end
            end
            StInit: begin
                data0_d = 1'b0;
                if (!nstatus_s) begin
                    state_d = StError;
                    err_d   = 2'b10;
                end else if (phase_end) begin
                    div_d = '0;
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else begin
                        dclk_d = 1'b0;
                        if (cnt_q == CntW'(INIT_CLKS - 1)) begin
                            state_d = StDone;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (overflow) begin
            state_d = StError;
            err_d   = 2'b11;
        end
        if (abort_i) begin
            state_d = StIdle;
            err_d   = 2'b00;
            cnt_d   = '0;
        end
        if (state_d inside {StIdle, StDone, StError}) flush = 1'b1;
        if (!(state_d inside {StShift, StInit})) begin
            dclk_d     = 1'b0;
            data0_d    = 1'b0;
            sh_valid_d = 1'b0;
            div_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            sh_valid_q <= 1'b0;
            dclk_q     <= 1'b0;
            data0_q    <= 1'b0;
            err_q      <= 2'b00;
            ncfg_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            sh_valid_q <= sh_valid_d;
            dclk_q     <= dclk_d;
            data0_q    <= data0_d;
            err_q      <= err_d;
            ncfg_q     <= (state_d == StNcfg);
            oe_q       <= state_d inside {StShift, StInit};
            busy_q     <= state_d inside {StNcfg, StWaitNs, StShift, StInit};
            done_q     <= (state_d == StDone);
            error_q    <= (state_d == StError);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + LvlW'(push) - LvlW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= wr_data_i;
    end

    assign nconfig_low_o = ncfg_q;
    assign pin_oe_o      = oe_q;
    assign dclk_o        = dclk_q;
    assign data0_o       = data0_q;
    assign fifo_full_o   = fifo_full;
    assign fifo_level_o  = level_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign err_code_o    = err_q;

endmodule

// File: tb/tb_ps_config_ctrl.sv
// Directed bench for ps_config_ctrl: instance A (DW=8, CLK_DIV=2, depth 4) and
// instance B (DW=16, CLK_DIV=1) with dclk-rise capture of data0.
module tb_ps_config_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int base = 0;

    // Instance A
    logic       a_rst_n, a_start, a_abort, a_wr_stb, a_nstatus, a_conf_done;
    logic [7:0] a_wr_data;
    logic       a_ncfg_low, a_pin_oe, a_dclk, a_data0, a_full, a_busy, a_done, a_error;
    logic [2:0] a_level;
    logic [1:0] a_err;

    // Instance B
    logic        b_rst_n, b_start, b_abort, b_wr_stb, b_nstatus, b_conf_done;
    logic [15:0] b_wr_data;
    logic        b_ncfg_low, b_pin_oe, b_dclk, b_data0, b_full, b_busy, b_done, b_error;
    logic [4:0]  b_level;
    logic [1:0]  b_err;

    ps_config_ctrl #(
        .DW(8), .FIFO_DEPTH(4), .CLK_DIV(2), .NCFG_LOW_CYC(10), .NSTAT_TMO(50), .INIT_CLKS(16)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .start_i(a_start), .abort_i(a_abort),
        .wr_stb_i(a_wr_stb), .wr_data_i(a_wr_data), .nstatus_i(a_nstatus),
        .conf_done_i(a_conf_done), .nconfig_low_o(a_ncfg_low), .pin_oe_o(a_pin_oe),
        .dclk_o(a_dclk), .data0_o(a_data0), .fifo_full_o(a_full), .fifo_level_o(a_level),
        .busy_o(a_busy), .done_o(a_done), .error_o(a_error), .err_code_o(a_err)
    );

    ps_config_ctrl #(
        .DW(16), .FIFO_DEPTH(16), .CLK_DIV(1), .NCFG_LOW_CYC(10), .NSTAT_TMO(50), .INIT_CLKS(4)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .start_i(b_start), .abort_i(b_abort),
        .wr_stb_i(b_wr_stb), .wr_data_i(b_wr_data), .nstatus_i(b_nstatus),
        .conf_done_i(b_conf_done), .nconfig_low_o(b_ncfg_low), .pin_oe_o(b_pin_oe),
        .dclk_o(b_dclk), .data0_o(b_data0), .fifo_full_o(b_full), .fifo_level_o(b_level),
        .busy_o(b_busy), .done_o(b_done), .error_o(b_error), .err_code_o(b_err)
    );

    // Rise capture: data0 and cycle number at every dclk rising edge.
    logic a_dclk_prev = 1'b0, b_dclk_prev = 1'b0, a_oe_prev = 1'b0;
    int   a_rn = 0, b_rn = 0, a_oe_cyc = 0, a_ncfg_n = 0;
    logic a_rbits [256];
    logic b_rbits [256];
    int   a_rcyc  [256];
    int   b_rcyc  [256];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        a_dclk_prev <= a_dclk;
        b_dclk_prev <= b_dclk;
        a_oe_prev   <= a_pin_oe;
        if (a_ncfg_low) a_ncfg_n <= a_ncfg_n + 1;
        if (a_pin_oe && !a_oe_prev) a_oe_cyc <= cyc;
        if (a_dclk && !a_dclk_prev && a_rn < 256) begin
            a_rbits[a_rn] <= a_data0;
            a_rcyc[a_rn]  <= cyc;
            a_rn          <= a_rn + 1;
        end
        if (b_dclk && !b_dclk_prev && b_rn < 256) begin
            b_rbits[b_rn] <= b_data0;
            b_rcyc[b_rn]  <= cyc;
            b_rn          <= b_rn + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] a_bits(input int b, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) if (b + i < 256) v[i] = a_rbits[b + i];
        return v;
    endfunction

    function automatic logic [31:0] b_bits(input int b, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) if (b + i < 256) v[i] = b_rbits[b + i];
        return v;
    endfunction

    task automatic a_wait_release(input string tag);
        for (int i = 0; i < 200 && a_ncfg_low; i++) tick();
        check_eq(tag, a_ncfg_low, 0);
    endtask

    task automatic b_wait_release(input string tag);
        for (int i = 0; i < 200 && b_ncfg_low; i++) tick();
        check_eq(tag, b_ncfg_low, 0);
    endtask

    task automatic a_wait_rises(input string tag, input int target);
        for (int i = 0; i < 2000 && a_rn < target; i++) tick();
        check_eq(tag, a_rn >= target, 1);
    endtask

    task automatic b_wait_rises(input string tag, input int target);
        for (int i = 0; i < 2000 && b_rn < target; i++) tick();
        check_eq(tag, b_rn >= target, 1);
    endtask

    task automatic a_push(input logic [7:0] w);
        a_wr_stb = 1'b1; a_wr_data = w; tick(); a_wr_stb = 1'b0;
    endtask

    task automatic b_push(input logic [15:0] w);
        b_wr_stb = 1'b1; b_wr_data = w; tick(); b_wr_stb = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_rst_n = 0; a_start = 0; a_abort = 0; a_wr_stb = 0; a_wr_data = '0;
        a_nstatus = 0; a_conf_done = 0;
        b_rst_n = 0; b_start = 0; b_abort = 0; b_wr_stb = 0; b_wr_data = '0;
        b_nstatus = 0; b_conf_done = 0;
        tick(2);
        check_eq("a_reset_outs", {a_ncfg_low, a_pin_oe, a_dclk, a_data0, a_full, a_busy,
                                  a_done, a_error, a_err, a_level}, 0);
        check_eq("b_reset_outs", {b_ncfg_low, b_pin_oe, b_dclk, b_data0, b_full, b_busy,
                                  b_done, b_error, b_err, b_level}, 0);
        a_rst_n = 1; b_rst_n = 1;
        tick(2);

        // Nominal run on A
        base = a_ncfg_n;
        a_start = 1; tick(); a_start = 0;
        check_eq("a_start_ncfg", {a_ncfg_low, a_busy}, 2'b11);
        a_push(8'hA5);
        a_push(8'h3C);
        check_eq("a_level_2", a_level, 2);
        a_wait_release("a_release1");
        check_eq("a_ncfg_width", a_ncfg_n - base, 10);
        tick(10);
        a_nstatus = 1;
        base = a_rn;
        a_wait_rises("a_rises16", base + 16);
        check_eq("a_bits", a_bits(base, 16), 32'h3CA5);
        check_eq("a_period", a_rcyc[base + 1] - a_rcyc[base], 4);
        check_eq("a_word_gap", a_rcyc[base + 8] - a_rcyc[base + 7], 5);
        check_eq("a_first_rise", a_rcyc[base] - a_oe_cyc, 3);
        a_conf_done = 1;
        base = a_rn;
        for (int i = 0; i < 400 && !a_done; i++) tick();
        check_eq("a_done", {a_done, a_pin_oe, a_busy, a_dclk, a_error}, 5'b10000);
        check_eq("a_init_clks", a_rn - base, 16);
        check_eq("a_init_data0", a_bits(base, 16), 0);

        // nSTATUS timeout on A
        a_conf_done = 0; a_nstatus = 0;
        a_start = 1; tick(); a_start = 0;
        check_eq("a_restart", {a_done, a_ncfg_low}, 2'b01);
        a_wait_release("a_release2");
        tick(49);
        check_eq("a_tmo_early", a_error, 0);
        tick();
        check_eq("a_tmo", {a_error, a_err, a_ncfg_low, a_busy}, 5'b1_01_0_0);

        // FIFO overflow on A
        a_start = 1; tick(); a_start = 0;
        check_eq("a_err_cleared", {a_error, a_err}, 0);
        a_wait_release("a_release3");
        a_wr_stb = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_data = 8'(i + 1);
            tick();
        end
        check_eq("a_full", {a_full, a_level, a_error}, {1'b1, 3'd4, 1'b0});
        tick();
        a_wr_stb = 0;
        check_eq("a_ovf", {a_error, a_err, a_level, a_full}, {1'b1, 2'b11, 3'd0, 1'b0});

        // nSTATUS low mid-word on A
        a_start = 1; tick(); a_start = 0;
        a_push(8'hA5);
        a_push(8'h3C);
        a_wait_release("a_release4");
        tick(10);
        a_nstatus = 1;
        base = a_rn;
        a_wait_rises("a_rises3", base + 3);
        check_eq("a_lvl_mid", a_level, 1);
        a_nstatus = 0;
        tick(2);
        check_eq("a_ns_early", a_error, 0);
        tick();
        check_eq("a_ns_err", {a_error, a_err, a_level, a_pin_oe, a_busy},
                 {1'b1, 2'b10, 3'd0, 1'b0, 1'b0});

        // Abort mid-INIT on A, then a clean run
        a_start = 1; tick(); a_start = 0;
        a_push(8'hA5);
        a_wait_release("a_release5");
        tick(10);
        a_nstatus = 1;
        base = a_rn;
        a_wait_rises("a_rises8", base + 8);
        a_conf_done = 1;
        a_wait_rises("a_init3", base + 11);
        check_eq("a_in_init", {a_pin_oe, a_busy, a_done}, 3'b110);
        a_abort = 1; tick(); a_abort = 0;
        check_eq("a_abort_outs", {a_ncfg_low, a_pin_oe, a_dclk, a_data0, a_full, a_busy,
                                  a_done, a_error, a_err, a_level}, 0);
        a_nstatus = 0; a_conf_done = 0;
        tick(3);
        a_start = 1; tick(); a_start = 0;
        a_push(8'h96);
        a_wait_release("a_release6");
        tick(10);
        a_nstatus = 1;
        base = a_rn;
        a_wait_rises("a_rises_clean", base + 8);
        check_eq("a_clean_bits", a_bits(base, 8), 32'h96);
        a_conf_done = 1;
        for (int i = 0; i < 400 && !a_done; i++) tick();
        check_eq("a_clean_done", {a_done, a_pin_oe, a_error}, 3'b100);

        // DW=16, CLK_DIV=1 on B with conf_done after bit 5
        b_start = 1; tick(); b_start = 0;
        b_push(16'h8001);
        b_wait_release("b_release1");
        tick(10);
        b_nstatus = 1;
        base = b_rn;
        b_wait_rises("b_rises6", base + 6);
        b_conf_done = 1;
        for (int i = 0; i < 400 && !b_done; i++) tick();
        check_eq("b_done", {b_done, b_pin_oe, b_error}, 3'b100);
        check_eq("b_rise_count", b_rn - base, 11);
        check_eq("b_bits", b_bits(base, 11), 32'h001);
        check_eq("b_period", b_rcyc[base + 1] - b_rcyc[base], 2);

        // Reset asserted mid-SHIFT on B, then a clean run
        b_conf_done = 0; b_nstatus = 0;
        b_start = 1; tick(); b_start = 0;
        b_push(16'h1234);
        b_wait_release("b_release2");
        tick(10);
        b_nstatus = 1;
        base = b_rn;
        b_wait_rises("b_rises4", base + 4);
        check_eq("b_in_shift", {b_pin_oe, b_busy, b_level}, {1'b1, 1'b1, 5'd0});
        b_rst_n = 0;
        #1;
        check_eq("b_async_reset", {b_ncfg_low, b_pin_oe, b_dclk, b_data0, b_full, b_busy,
                                   b_done, b_error, b_err, b_level}, 0);
        tick(2);
        b_rst_n = 1; b_nstatus = 0;
        tick();
        b_start = 1; tick(); b_start = 0;
        b_push(16'hC3A5);
        b_wait_release("b_release3");
        tick(10);
        b_nstatus = 1;
        base = b_rn;
        b_wait_rises("b_rises16", base + 16);
        check_eq("b_clean_bits", b_bits(base, 16), 32'hC3A5);
        b_conf_done = 1;
        for (int i = 0; i < 400 && !b_done; i++) tick();
        check_eq("b_clean_done", {b_done, b_pin_oe, b_error}, 3'b100);
        check_eq("b_clean_rises", b_rn - base, 20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
